// File: rtl/sram_sp_arbiter_if.sv
// rtl/sram_sp_arbiter_if.sv - request, response and macro signals of sram_sp_arbiter
// Purpose: bundles the two requester ports, the init status and the SRAM macro pins.
// Signals:
//   pX_valid/pX_ready/pX_wen/pX_addr/pX_wdata : request handshake, port X (0/1)
//   pX_rvalid/pX_rdata                        : read response, port X
//   init_done                                 : zero-fill finished (or skipped)
//   sram_ceb/sram_web/sram_a/sram_d/sram_q    : single-port macro pins
// Modports: slave = arbiter view, master = requester/macro view.
interface sram_sp_arbiter_if #(
  parameter int BITS = 8,
  parameter int AW   = 7
);
  logic            p0_valid;
  logic            p0_ready;
  logic            p0_wen;
  logic [AW-1:0]   p0_addr;
  logic [BITS-1:0] p0_wdata;
  logic            p0_rvalid;
  logic [BITS-1:0] p0_rdata;

  logic            p1_valid;
  logic            p1_ready;
  logic            p1_wen;
  logic [AW-1:0]   p1_addr;
  logic [BITS-1:0] p1_wdata;
  logic            p1_rvalid;
  logic [BITS-1:0] p1_rdata;

  logic            init_done;

  logic            sram_ceb;
  logic            sram_web;
  logic [AW-1:0]   sram_a;
  logic [BITS-1:0] sram_d;
  logic [BITS-1:0] sram_q;

  modport slave (
    input  p0_valid, p0_wen, p0_addr, p0_wdata,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_valid, p1_wen, p1_addr, p1_wdata,
    output p1_ready, p1_rvalid, p1_rdata,
    output init_done,
    output sram_ceb, sram_web, sram_a, sram_d,
    input  sram_q
  );

  modport master (
    output p0_valid, p0_wen, p0_addr, p0_wdata,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_valid, p1_wen, p1_addr, p1_wdata,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  init_done,
    input  sram_ceb, sram_web, sram_a, sram_d,
    output sram_q
  );
endinterface

// File: rtl/sram_sp_arbiter.sv
// rtl/sram_sp_arbiter.sv - two-port round-robin front end for a single-port SRAM macro
// Purpose: zero-fills the macro after reset, then arbitrates one access per cycle
//   between two valid/ready requesters and returns read data with held results.
// Ports:
//   CLK  : clock, all state on posedge
//   RSTB : asynchronous active-low reset
//   bus  : sram_sp_arbiter_if.slave (requester ports, init_done, macro pins)
module sram_sp_arbiter #(
  parameter int BITS    = 8,
  parameter int DEPTH   = 128,
  parameter int AW      = 7,
  parameter int INIT_EN = 1
) (
  input  logic                CLK,
  input  logic                RSTB,
  sram_sp_arbiter_if.slave    bus
);

  typedef enum logic {ST_INIT, ST_SERVE} state_t;
  localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_SERVE;

  state_t          state;
  state_t          state_nxt;
  // live is 0 only during reset and the cycle after release, so the macro pins
  // show their idle reset values until the first clock edge out of reset.
  logic            live;
  logic [AW-1:0]   cnt;
  logic            done;
  // rr names the port that wins when both request at once.
  logic            rr;
  logic [1:0]      pend;
  logic [BITS-1:0] hold0;
  logic [BITS-1:0] hold1;

  logic            gnt_v;
  logic            gnt_id;
  logic            ceb;
  logic            web;
  logic [AW-1:0]   a;
  logic [BITS-1:0] d;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_v     = 1'b0;
    gnt_id    = 1'b0;
    ceb       = 1'b1;
    web       = 1'b1;
    a         = cnt;
    d         = '0;
    case (state)
      ST_INIT: begin
        if (live) begin
          ceb = 1'b0;
          web = 1'b0;
          if (cnt == AW'(DEPTH - 1)) begin
            state_nxt = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (done) begin
          if (bus.p0_valid && bus.p1_valid) begin
            gnt_v  = 1'b1;
            gnt_id = rr;
          end else if (bus.p0_valid) begin
            gnt_v  = 1'b1;
          end else if (bus.p1_valid) begin
            gnt_v  = 1'b1;
            gnt_id = 1'b1;
          end
          if (gnt_v) begin
            ceb = 1'b0;
            web = gnt_id ? ~bus.p1_wen   : ~bus.p0_wen;
            a   = gnt_id ?  bus.p1_addr  :  bus.p0_addr;
            d   = gnt_id ?  bus.p1_wdata :  bus.p0_wdata;
          end
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      live  <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      rr    <= 1'b0;
      pend  <= 2'b00;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      live <= 1'b1;
      if (state == ST_INIT && live) begin
        cnt <= cnt + 1'b1;
      end
      done <= (state_nxt == ST_SERVE);
      if (gnt_v) begin
        rr <= ~gnt_id;
      end
      pend[0] <= gnt_v & ~gnt_id & ~bus.p0_wen;
      pend[1] <= gnt_v &  gnt_id & ~bus.p1_wen;
      // Macro Q is only meaningful in the cycle after a read; capture it then.
      if (pend[0]) begin
        hold0 <= bus.sram_q;
      end
      if (pend[1]) begin
        hold1 <= bus.sram_q;
      end
    end
  end

  assign bus.p0_ready  = gnt_v & ~gnt_id;
  assign bus.p1_ready  = gnt_v &  gnt_id;
  assign bus.p0_rvalid = pend[0];
  assign bus.p1_rvalid = pend[1];
  assign bus.p0_rdata  = pend[0] ? bus.sram_q : hold0;
  assign bus.p1_rdata  = pend[1] ? bus.sram_q : hold1;
  assign bus.init_done = done;
  assign bus.sram_ceb  = ceb;
  assign bus.sram_web  = web;
  assign bus.sram_a    = a;
  assign bus.sram_d    = d;

endmodule
